// File: rtl/leaf_parent_tx_pkg.sv
// Uplink word layout shared by the leaf transmitter and the root hub receiver.
// pack_word is the single source of truth for where each header field sits.
package leaf_parent_tx_pkg;

  localparam int WORD_W      = 64;
  localparam int DEST_LSB    = 56;
  localparam int DEST_W      = 8;
  localparam int SRC_LSB     = 48;
  localparam int SRC_W       = 8;
  localparam int TYPE_LSB    = 44;
  localparam int TYPE_W      = 4;
  localparam int PAYLOAD_LSB = 0;
  localparam int PAYLOAD_W   = 44;

  localparam logic [TYPE_W-1:0] MSG_TYPE_REPORT = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_EMIT
  } tx_state_e;

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [DEST_W-1:0]    dest,
    input logic [SRC_W-1:0]     src,
    input logic [TYPE_W-1:0]    mtype,
    input logic [PAYLOAD_W-1:0] payload
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[DEST_LSB +: DEST_W]       = dest;
    w[SRC_LSB +: SRC_W]         = src;
    w[TYPE_LSB +: TYPE_W]       = mtype;
    w[PAYLOAD_LSB +: PAYLOAD_W] = payload;
    return w;
  endfunction

endpackage

// File: rtl/leaf_parent_tx_sync_fifo_fwft.sv
// First-word-fall-through FIFO: head always shows the oldest entry while not empty.
// Full/empty derive from the registered count only, so they never depend on push/pop.
module sync_fifo_fwft #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/leaf_parent_tx.sv
// Leaf-to-root uplink transmitter: FIFO plus one output register, with a round
// report word carrying the number of data words sent since the previous report.
module leaf_parent_tx
  import leaf_parent_tx_pkg::*;
#(
  parameter int FPGA_ID       = 1,
  parameter int ROOT_ID       = 0,
  parameter int FIFO_DEPTH    = 8,
  parameter int PAYLOAD_WIDTH = 44,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_type,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  input  logic                     report_req,
  output logic                     report_busy,
  output logic [63:0]              parent_tx_data,
  output logic                     parent_tx_valid,
  input  logic                     parent_tx_ready,
  output logic [CW-1:0]            fifo_count
);

  localparam logic [DEST_W-1:0] DEST_ID = DEST_W'(ROOT_ID);
  localparam logic [SRC_W-1:0]  SRC_ID  = SRC_W'(FPGA_ID);
  localparam int                FW      = TYPE_W + PAYLOAD_W;

  tx_state_e            state_reg;
  logic                 oreg_valid_reg;
  logic                 oreg_report_reg;
  logic [63:0]          oreg_data_reg;
  logic [PAYLOAD_W-1:0] sent_reg;
  logic                 busy_reg;

  logic          fifo_full;
  logic          fifo_empty;
  logic [FW-1:0] fifo_head;
  logic          out_xfer;
  logic          oreg_free;
  logic          in_xfer;
  logic          bypass;
  logic          fifo_push;
  logic          fifo_pop;
  logic          load_report;

  assign out_xfer    = oreg_valid_reg && parent_tx_ready;
  assign oreg_free   = !oreg_valid_reg || out_xfer;
  assign in_ready    = reset && (state_reg == ST_RUN) && !fifo_full;
  assign in_xfer     = in_valid && in_ready;
  assign load_report = (state_reg == ST_EMIT) && !oreg_valid_reg;
  // An empty FIFO with a free OREG lets the message skip the FIFO entirely.
  assign bypass      = in_xfer && fifo_empty && oreg_free;
  assign fifo_push   = in_xfer && !bypass;
  assign fifo_pop    = oreg_free && !fifo_empty && !load_report;

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({in_type, in_payload}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= ST_RUN;
      oreg_valid_reg  <= 1'b0;
      oreg_report_reg <= 1'b0;
      oreg_data_reg   <= '0;
      sent_reg        <= '0;
      busy_reg        <= 1'b0;
    end else begin
      if (out_xfer && !oreg_report_reg && (sent_reg != '1))
        sent_reg <= sent_reg + 1'b1;

      case (state_reg)
        ST_RUN: begin
          if (report_req) begin
            state_reg <= ST_DRAIN;
            busy_reg  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty && oreg_free) state_reg <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_xfer && oreg_report_reg) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= ST_RUN;
      endcase

      // OREG is always empty on EMIT entry, so the report load never races a data transfer.
      if (load_report) begin
        oreg_data_reg   <= pack_word(DEST_ID, SRC_ID, MSG_TYPE_REPORT, sent_reg);
        oreg_valid_reg  <= 1'b1;
        oreg_report_reg <= 1'b1;
        sent_reg        <= '0;
      end else if (fifo_pop) begin
        oreg_data_reg   <= pack_word(DEST_ID, SRC_ID, fifo_head[FW-1 -: TYPE_W],
                                     fifo_head[PAYLOAD_W-1:0]);
        oreg_valid_reg  <= 1'b1;
        oreg_report_reg <= 1'b0;
      end else if (bypass) begin
        oreg_data_reg   <= pack_word(DEST_ID, SRC_ID, in_type, in_payload);
        oreg_valid_reg  <= 1'b1;
        oreg_report_reg <= 1'b0;
      end else if (out_xfer) begin
        oreg_valid_reg  <= 1'b0;
        oreg_report_reg <= 1'b0;
      end
    end
  end

  assign parent_tx_valid = oreg_valid_reg;
  assign parent_tx_data  = oreg_data_reg;
  assign report_busy     = busy_reg;

endmodule

// File: tb/tb_leaf_parent_tx.sv
// Randomized bench for leaf_parent_tx against a queue-based model of the uplink:
// accepted messages line up in order, and a round report carries the words sent.
module tb_leaf_parent_tx;

  localparam int DEPTH = 8;
  localparam logic [7:0] ROOT = 8'h00;
  localparam logic [7:0] SRC  = 8'h01;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_type;
  logic [43:0] in_payload;
  logic        report_req;
  logic        report_busy;
  logic [63:0] parent_tx_data;
  logic        parent_tx_valid;
  logic        parent_tx_ready;
  logic [3:0]  fifo_count;

  leaf_parent_tx #(
    .FPGA_ID       (1),
    .ROOT_ID       (0),
    .FIFO_DEPTH    (DEPTH),
    .PAYLOAD_WIDTH (44)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_type         (in_type),
    .in_payload      (in_payload),
    .report_req      (report_req),
    .report_busy     (report_busy),
    .parent_tx_data  (parent_tx_data),
    .parent_tx_valid (parent_tx_valid),
    .parent_tx_ready (parent_tx_ready),
    .fifo_count      (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_reports = 0;

  // Model: words accepted but not yet sent, round state and words sent this round.
  logic [63:0] q[$];
  logic        busy_m;
  logic        rep_shown;
  logic [43:0] cnt_m;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input logic v, input logic [3:0] t, input logic [43:0] p,
                      input logic rq, input logic rd, input logic rs);
    int   fc_exp;
    logic ir_exp;
    logic busy_before;
    @(negedge clk);
    in_valid = v; in_type = t; in_payload = p;
    report_req = rq; parent_tx_ready = rd; reset = rs;
    #1;
    fc_exp = (q.size() > 0) ? q.size() - 1 : 0;
    ir_exp = rs && !busy_m && (fc_exp < DEPTH);
    check_val("in_ready", 64'(in_ready), 64'(ir_exp));
    check_val("fifo_count", 64'(fifo_count), 64'(fc_exp));
    check_val("report_busy", 64'(report_busy), 64'(busy_m));
    if (q.size() > 0) begin
      check_val("data_valid", 64'(parent_tx_valid), 64'd1);
      check_val("data_word", parent_tx_data, q[0]);
    end else if (!busy_m) begin
      check_val("idle_valid", 64'(parent_tx_valid), 64'd0);
    end else begin
      if (rep_shown) check_val("report_hold", 64'(parent_tx_valid), 64'd1);
      if (parent_tx_valid) check_val("report_word", parent_tx_data, {ROOT, SRC, 4'hF, cnt_m});
    end

    busy_before = busy_m;
    if (!rs) begin
      q.delete();
      busy_m = 1'b0;
      rep_shown = 1'b0;
      cnt_m = '0;
    end else begin
      if (parent_tx_valid && rd) begin
        $display("xfer word=%h", parent_tx_data);
        if (q.size() > 0) begin
          void'(q.pop_front());
          if (cnt_m != '1) cnt_m = cnt_m + 1'b1;
        end else if (busy_m) begin
          busy_m = 1'b0;
          rep_shown = 1'b0;
          cnt_m = '0;
          n_reports++;
        end
      end else if (parent_tx_valid && busy_m && q.size() == 0) begin
        rep_shown = 1'b1;
      end
      if (v && ir_exp) q.push_back({ROOT, SRC, t, p});
      if (rq && !busy_before) busy_m = 1'b1;
    end
  endtask

  function automatic logic [3:0] rtype();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic [43:0] rpay();
    return 44'({$urandom(), $urandom()});
  endfunction

  initial begin
    logic done;
    int pv, pr;
    q.delete();
    busy_m = 1'b0; rep_shown = 1'b0; cnt_m = '0;
    in_valid = 1'b0; in_type = '0; in_payload = '0;
    report_req = 1'b0; parent_tx_ready = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, including in_ready forced low while reset is held.
    step(1, 4'h3, 44'h7, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);

    // Basic latency: word appears the cycle after acceptance and leaves after one cycle.
    step(1, 4'h1, 44'h123, 0, 1, 1);
    @(posedge clk); #1;
    check_val("basic_valid", 64'(parent_tx_valid), 64'd1);
    check_val("basic_word", parent_tx_data, 64'h0001_1000_0000_0123);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);

    // Backpressure: 9 accepted (8 FIFO + OREG), tenth refused; then drain.
    for (int i = 0; i < 10; i++) step(1, rtype(), rpay(), 0, 0, 1);
    @(posedge clk); #1;
    check_val("bp_count", 64'(fifo_count), 64'd8);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0, 1, 1);

    // Full FIFO with simultaneous pop and in_valid held.
    for (int i = 0; i < 30; i++) step(1, rtype(), rpay(), 0, (i >= 9), 1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 1);

    // Report with 3 words still queued after 2 have left.
    for (int i = 0; i < 5; i++) step(1, rtype(), rpay(), 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 10; i++) step(1, rtype(), rpay(), 0, 1, 1);

    // Report with ready toggling and a second request during DRAIN.
    for (int i = 0; i < 4; i++) step(1, rtype(), rpay(), 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, (i == 2), i[0], 1);
    check_val("report_total", 64'(n_reports), 64'd2);

    // Reset while the report word is parked on the link.
    step(1, rtype(), rpay(), 0, 0, 1);
    step(1, rtype(), rpay(), 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 10 && q.size() > 0; i++) step(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10 && !rep_shown; i++) step(0, 0, 0, 0, 0, 1);
    check_val("emit_reached", 64'(rep_shown), 64'd1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 4'h2, 44'hABC, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);

    // Random segments with varying input/ready pressure and rare resets.
    for (int s = 0; s < 5; s++) begin
      pv = 20 + s * 20;
      pr = 90 - s * 15;
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 99) < pv, rtype(), rpay(),
             $urandom_range(0, 99) < 3, $urandom_range(0, 99) < pr,
             $urandom_range(0, 399) != 0);
      end
    end

    // Bounded final drain.
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step(0, 0, 0, 0, 1, 1);
      done = !busy_m && (q.size() == 0) && !parent_tx_valid;
    end
    check_val("final_drain", 64'(done), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/leaf_parent_tx.md
Name: leaf_parent_tx

Overview:
- Leaf-side transmitter for the 64-bit valid/ready uplink from a leaf FPGA to the root hub. It drives the `parent_tx_*` channel that the root consumes on `up_rx_*`.
- Accepts typed messages from the local decoder and stamps each with a header.
- Buffers messages in a small FIFO and streams them to the root.
- On request, drains the FIFO and then emits one end-of-round report word carrying the count of words sent in the round.

Parameters:
- FPGA_ID, 1, source ID stamped into every header (8-bit field).
- ROOT_ID, 0, destination ID for all words.
- FIFO_DEPTH, 8, buffer entries; power of two, at least 2.
- PAYLOAD_WIDTH, 44, payload width; fixed by the word format.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low; 0 = reset, sampled on the rising edge of clk.
- in_valid  in  1  local message valid.
- in_ready  out  1  block can accept a message.
- in_type  in  4  message type; 4'hF is reserved.
- in_payload  in  44  message payload.
- report_req  in  1  one-cycle pulse: close the round.
- report_busy  out  1  high from report_req acceptance until the report word handshakes.
- parent_tx_data  out  64  uplink word.
- parent_tx_valid  out  1  uplink valid.
- parent_tx_ready  in  1  uplink ready from the root.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy, output register excluded.

Behaviour:
- Word format:
  - [63:56] ROOT_ID
  - [55:48] FPGA_ID
  - [47:44] type
  - [43:0] payload
- Handshakes:
  - Input transfer: in_valid && in_ready.
  - Output transfer: parent_tx_valid && parent_tx_ready.
  - Once parent_tx_valid is high, it and parent_tx_data hold stable until the output transfer occurs.
- Reset values: parent_tx_valid=0, parent_tx_data=0, in_ready=0 during reset, report_busy=0, fifo_count=0, sent counter=0, state RUN. Any in-flight message is discarded.
- Structure: FIFO feeding a single output register (OREG).
  - OREG loads whenever it is empty, or is being transferred in the same cycle, and a word is available.
- Latency and bypass:
  - A message accepted at cycle N while the FIFO and OREG are empty appears on parent_tx_valid at N+1 (FIFO bypass).
  - With parent_tx_ready held high, sustained throughput is 1 word/cycle.
- in_ready rule: high only when state is RUN, reset is deasserted, and the FIFO is not full.
- Full FIFO: a simultaneous pop (OREG load) does NOT raise in_ready in that cycle. in_ready is registered-safe and depends only on current occupancy.
- Empty FIFO with in_valid and OREG load in the same cycle: bypass into OREG; fifo_count is unchanged.
- Pointers: wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- Sent counter:
  - 44-bit counter increments on every output transfer of a non-report word.
  - Saturates at all-ones.
- State machine:
  - RUN: normal operation. report_req=1 → DRAIN, and report_busy goes high the next cycle. report_req while not in RUN is ignored.
  - DRAIN: in_ready=0. When the FIFO is empty and OREG is empty, or OREG is transferring its last word this cycle, → EMIT.
  - EMIT: OREG loads the report word: type 4'hF, payload = sent counter, including any word transferred in the DRAIN exit cycle. The sent counter clears in the same cycle. On the report word's output transfer → RUN, report_busy=0, and in_ready may rise the next cycle.
- report_req coinciding with in_valid in RUN: the message is accepted if in_ready is high and is counted in this round.
- in_type 4'hF from the local side: accepted as-is (no checking); it is the caller's error.
- Reset mid-operation (including mid-EMIT): everything returns to reset values the next cycle. No partial word remains on the link.

Decomposition:
- Shared package (for example `uplink_pkg`):
  - Field offsets and widths: DEST, SRC, TYPE, PAYLOAD.
  - MSG_TYPE_REPORT = 4'hF.
  - A function that packs header and payload into a 64-bit word. The root hub receiver uses the same function to unpack.
- Sub-module `sync_fifo_fwft`: parameterized width and depth, with count, full and empty outputs and active-low synchronous reset.
- Top level: state machine, OREG, bypass path and counter.

Test Plan:
- Basic: after reset, push type=1, payload=44'h123 with parent_tx_ready=1. Expect data 64'h00_01_1_00000000123 (ROOT_ID=0, FPGA_ID=1) with valid at N+1, held for exactly 1 cycle.
- Backpressure: parent_tx_ready=0, push 9 messages.
  - in_ready drops after the 9th accept: 8 in the FIFO plus 1 in OREG, fifo_count=8.
  - Data stays stable.
  - After releasing ready, all 9 emerge in order, 1 per cycle.
- Full plus simultaneous pop: with the FIFO full and ready=1, hold in_valid. in_ready stays low that cycle and rises the next. No loss and no duplication over 20 random words.
- Report: send 5 words, then pulse report_req while 3 remain queued.
  - in_ready stays low.
  - The 3 remaining words are followed by report word type F with payload 5.
  - report_busy is high throughout, and the next round's counter restarts at 0.
- Report with ready toggling every cycle: the report word is held stable until accepted. A second report_req during DRAIN is ignored, so exactly one report word is sent.
- Reset mid-EMIT with parent_tx_valid=1: pull reset low for 1 cycle. Next cycle parent_tx_valid=0, fifo_count=0, report_busy=0. A new message then follows the N+1 latency.
